hdr_gen_stream: RTL and testbench

Parametrised picture-header and slice-table generator for the ProRes bitstream path. Emits an ordered sequence of (value, bit-length) fields to the downstream bit writer using a valid/ready handshake. Frame fields are captured from ports at start; slice sizes are read from an external slice-size table. Sits between the frame controller and the bit writer, ahead of slice data emission.

---
 rtl/hdr_gen_stream.sv | 192 +++++++++++++++++++
 tb/tb_hdr_gen_stream.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_gen_stream.sv
// Picture-header and slice-table field generator feeding the bit writer over valid/ready.
// Optional trailing flush beat enabled by defining HDR_GEN_FLUSH_EN.
module hdr_gen_stream #(
    parameter int MAX_SLICES    = 64,
    parameter int VAL_W         = 64,
    parameter int LEN_W         = 64,
    parameter int PIC_HDR_BYTES = 8,
    localparam int AW           = (MAX_SLICES > 1) ? $clog2(MAX_SLICES) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [31:0]      picture_size,
    input  logic [15:0]      slice_num,
    input  logic [1:0]       log2_slice_mb,
    output logic [AW-1:0]    slice_rd_addr,
    input  logic [15:0]      slice_rd_data,
    input  logic             ready,
    output logic             output_enable,
    output logic [VAL_W-1:0] val,
    output logic [LEN_W-1:0] size_of_bit,
    output logic             flush_bit,
    output logic             busy,
    output logic             done
);

`ifdef HDR_GEN_FLUSH_EN
    typedef enum logic [2:0] {S_IDLE, S_FIELD, S_TABLE, S_FLUSH, S_DONE} state_t;
    logic flush_q;
`else
    typedef enum logic [2:0] {S_IDLE, S_FIELD, S_TABLE, S_DONE} state_t;
`endif

    state_t           state_q;
    logic [2:0]       fld_q;
    logic [AW-1:0]    idx_q;
    logic [31:0]      pic_q;
    logic [15:0]      cnt_q;
    logic [1:0]       log2_q;
    logic             oe_q;
    logic [VAL_W-1:0] val_q;
    logic [LEN_W-1:0] len_q;
    logic             busy_q;
    logic             done_q;

    logic [15:0]      num_clamped;
    logic [2:0]       fld_d;
    logic [VAL_W-1:0] fval_d;
    logic [LEN_W-1:0] flen_d;
    logic             last_tbl;

    always_comb begin
        num_clamped = ({16'd0, slice_num} > 32'(MAX_SLICES)) ? 16'(MAX_SLICES) : slice_num;
    end

    // Value/length of the field that follows the one currently presented.
    always_comb begin
        fld_d  = fld_q + 3'd1;
        fval_d = '0;
        flen_d = '0;
        case (fld_d)
            3'd1: flen_d = LEN_W'(3);
            3'd2: begin fval_d = VAL_W'(pic_q);  flen_d = LEN_W'(32); end
            3'd3: begin fval_d = VAL_W'(cnt_q);  flen_d = LEN_W'(16); end
            3'd4: flen_d = LEN_W'(2);
            3'd5: begin fval_d = VAL_W'(log2_q); flen_d = LEN_W'(2);  end
            3'd6: flen_d = LEN_W'(4);
            default: ;
        endcase
    end

    assign last_tbl = (16'(idx_q) == (cnt_q - 16'd1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            fld_q   <= '0;
            idx_q   <= '0;
            pic_q   <= '0;
            cnt_q   <= '0;
            log2_q  <= '0;
            oe_q    <= 1'b0;
            val_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef HDR_GEN_FLUSH_EN
            flush_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_FIELD;
                        fld_q   <= '0;
                        pic_q   <= picture_size;
                        cnt_q   <= num_clamped;
                        log2_q  <= log2_slice_mb;
                        oe_q    <= 1'b1;
                        val_q   <= VAL_W'(PIC_HDR_BYTES);
                        len_q   <= LEN_W'(5);
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        oe_q    <= 1'b0;
                        val_q   <= '0;
                        len_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                S_FIELD: begin
                    if (ready) begin
                        if (fld_q == 3'd6) begin
                            if (cnt_q != 16'd0) begin
                                state_q <= S_TABLE;
                                idx_q   <= '0;
                                val_q   <= '0;
                                len_q   <= LEN_W'(16);
                            end else begin
`ifdef HDR_GEN_FLUSH_EN
                                state_q <= S_FLUSH;
                                val_q   <= '0;
                                len_q   <= '0;
                                flush_q <= 1'b1;
`else
                                state_q <= S_DONE;
                                oe_q    <= 1'b0;
                                val_q   <= '0;
                                len_q   <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
`endif
                            end
                        end else begin
                            fld_q <= fld_d;
                            val_q <= fval_d;
                            len_q <= flen_d;
                        end
                    end
                end
                S_TABLE: begin
                    if (ready) begin
                        if (last_tbl) begin
                            idx_q <= '0;
`ifdef HDR_GEN_FLUSH_EN
                            state_q <= S_FLUSH;
                            len_q   <= '0;
                            flush_q <= 1'b1;
`else
                            state_q <= S_DONE;
                            oe_q    <= 1'b0;
                            len_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
`ifdef HDR_GEN_FLUSH_EN
                S_FLUSH: begin
                    if (ready) begin
                        state_q <= S_DONE;
                        oe_q    <= 1'b0;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Table beats pass the externally looked-up size straight through; the
    // address is the registered index, so the value is stable while stalled.
    assign val           = (state_q == S_TABLE) ? VAL_W'(slice_rd_data) : val_q;
    assign slice_rd_addr = idx_q;
    assign size_of_bit   = len_q;
    assign output_enable = oe_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef HDR_GEN_FLUSH_EN
    assign flush_bit     = flush_q;
`else
    assign flush_bit     = 1'b0;
`endif

endmodule

// File: tb/tb_hdr_gen_stream.sv
// Scoreboard bench for hdr_gen_stream: stimulus pushes expected beats, a
// negedge monitor pops and compares on every accepted beat.
module tb_hdr_gen_stream;
    localparam int MAX = 8;
    localparam int AW  = 3;
`ifdef HDR_GEN_FLUSH_EN
    localparam int FL = 1;
`else
    localparam int FL = 0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b1;
    logic [31:0] picture_size = '0;
    logic [15:0] slice_num = '0;
    logic [1:0]  log2_slice_mb = '0;
    logic [AW-1:0] slice_rd_addr;
    logic [15:0] slice_rd_data;
    logic        output_enable, flush_bit, busy, done;
    logic [63:0] val;
    logic [63:0] size_of_bit;
    logic [15:0] tbl [MAX];

    typedef struct packed {
        logic [63:0] v;
        logic [63:0] l;
        logic        f;
    } beat_t;

    beat_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    int ready_mode = 0;
    int lat;

    hdr_gen_stream #(
        .MAX_SLICES(MAX), .VAL_W(64), .LEN_W(64), .PIC_HDR_BYTES(8)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .picture_size(picture_size), .slice_num(slice_num),
        .log2_slice_mb(log2_slice_mb), .slice_rd_addr(slice_rd_addr),
        .slice_rd_data(slice_rd_data), .ready(ready),
        .output_enable(output_enable), .val(val), .size_of_bit(size_of_bit),
        .flush_bit(flush_bit), .busy(busy), .done(done)
    );

    assign slice_rd_data = tbl[slice_rd_addr];
    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push_beat(input logic [63:0] v, input logic [63:0] l, input logic f);
        beat_t b;
        b.v = v; b.l = l; b.f = f;
        sb.push_back(b);
    endfunction

    function automatic void push_seq(input logic [31:0] pic, input int num, input logic [1:0] l2);
        int c;
        c = (num > MAX) ? MAX : num;
        push_beat(64'd8, 64'd5, 1'b0);
        push_beat(64'd0, 64'd3, 1'b0);
        push_beat(64'(pic), 64'd32, 1'b0);
        push_beat(64'(c), 64'd16, 1'b0);
        push_beat(64'd0, 64'd2, 1'b0);
        push_beat(64'(l2), 64'd2, 1'b0);
        push_beat(64'd0, 64'd4, 1'b0);
        for (int i = 0; i < c; i++) push_beat(64'(tbl[i]), 64'd16, 1'b0);
        if (FL == 1) push_beat(64'd0, 64'd0, 1'b1);
    endfunction

    // Called at posedge+1; returns at posedge+1 after the acceptance edge.
    task automatic start_seq(input logic [31:0] pic, input logic [15:0] num, input logic [1:0] l2);
        picture_size  = pic;
        slice_num     = num;
        log2_slice_mb = l2;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_oe", 64'(output_enable), 64'd1);
    endtask

    task automatic wait_done(input int budget, input bit addr0, output int cycles);
        bit fin;
        cycles = 0;
        fin = 0;
        while (!fin) begin
            @(posedge clock); #1;
            cycles++;
            if (addr0) chk("addr_zero", 64'(slice_rd_addr), 64'd0);
            if (done) fin = 1;
            else if (cycles >= budget) begin
                n_checks++; n_fail++;
                $display("FAIL done_timeout: got no done after %0d cycles", cycles);
                fin = 1;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_oe"}, 64'(output_enable), 64'd0);
        chk({tag, "_val"}, val, 64'd0);
        chk({tag, "_len"}, size_of_bit, 64'd0);
        chk({tag, "_flush"}, 64'(flush_bit), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_addr"}, 64'(slice_rd_addr), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge clock); #1;
            if (ready_mode == 0) ready = 1'b1;
            else if (ready_mode == 1) ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops on acceptance, checks stall stability and done placement.
    initial begin
        bit    stall_prev, acc_prev;
        beat_t held, e;
        logic [AW-1:0] held_addr;
        stall_prev = 0; acc_prev = 0; held = '0; held_addr = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                stall_prev = 0;
                acc_prev = 0;
            end else begin
                if (stall_prev) begin
                    chk("stall_oe", 64'(output_enable), 64'd1);
                    chk("stall_val", val, held.v);
                    chk("stall_len", size_of_bit, held.l);
                    chk("stall_flush", 64'(flush_bit), 64'(held.f));
                    chk("stall_addr", 64'(slice_rd_addr), 64'(held_addr));
                end
                if (done) begin
                    chk("done_busy_low", 64'(busy), 64'd0);
                    chk("done_after_accept", 64'(acc_prev), 64'd1);
                end
                if (output_enable && ready) begin
                    if (sb.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL extra_beat: got val=0x%0h len=%0d expected no beat", val, size_of_bit);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_val", val, e.v);
                        chk("beat_len", size_of_bit, e.l);
                        chk("beat_flush", 64'(flush_bit), 64'(e.f));
                        $display("beat val=0x%0h len=%0d flush=%0b", val, size_of_bit, flush_bit);
                    end
                end
                stall_prev = output_enable && !ready;
                acc_prev   = output_enable && ready;
                held.v = val; held.l = size_of_bit; held.f = flush_bit;
                held_addr = slice_rd_addr;
            end
        end
    end

    initial begin
        for (int i = 0; i < MAX; i++) tbl[i] = '0;
        #12;
        check_idle_outputs("reset");
        @(negedge clock); #2 reset_n = 1'b1;
        @(posedge clock); #1;

        // Single slice, ready held high; latency includes the start cycle.
        tbl[0] = 16'h0424;
        push_seq(32'h42E, 1, 2'd3);
        start_seq(32'h42E, 16'd1, 2'd3);
        wait_done(100, 0, lat);
        chk("lat_one_slice", 64'(lat + 1), 64'(9 + FL));
        chk("sb_empty_1", 64'(sb.size()), 64'd0);
        @(posedge clock); #1;

        // Four slices with random ready stalls.
        tbl[0] = 16'h10; tbl[1] = 16'h20; tbl[2] = 16'h30; tbl[3] = 16'h40;
        ready_mode = 1;
        push_seq(32'h1234, 4, 2'd1);
        start_seq(32'h1234, 16'd4, 2'd1);
        wait_done(1000, 0, lat);
        chk("sb_empty_2", 64'(sb.size()), 64'd0);
        ready_mode = 0;
        @(posedge clock); #1;

        // Empty table: addr must stay 0 throughout.
        push_seq(32'h55, 0, 2'd2);
        start_seq(32'h55, 16'd0, 2'd2);
        wait_done(100, 1, lat);
        chk("lat_empty", 64'(lat + 1), 64'(8 + FL));
        chk("sb_empty_3", 64'(sb.size()), 64'd0);
        @(posedge clock); #1;

        // Oversized slice count is clamped.
        for (int i = 0; i < MAX; i++) tbl[i] = 16'(16'h100 + i);
        push_seq(32'h77, MAX + 5, 2'd0);
        start_seq(32'h77, 16'(MAX + 5), 2'd0);
        wait_done(100, 0, lat);
        chk("lat_clamp", 64'(lat + 1), 64'(16 + FL));
        chk("sb_empty_4", 64'(sb.size()), 64'd0);
        @(posedge clock); #1;

        // start held high: mid-sequence changes ignored, back-to-back restart.
        tbl[0] = 16'hA1; tbl[1] = 16'hA2;
        push_seq(32'h111, 2, 2'd1);
        picture_size = 32'h111; slice_num = 16'd2; log2_slice_mb = 2'd1;
        start = 1'b1;
        @(posedge clock); #1;
        chk("b2b_busy", 64'(busy), 64'd1);
        picture_size = 32'h222;
        wait_done(100, 0, lat);
        push_seq(32'h222, 2, 2'd1);
        @(posedge clock); #1;
        chk("b2b_restart_busy", 64'(busy), 64'd1);
        chk("b2b_restart_oe", 64'(output_enable), 64'd1);
        start = 1'b0;
        picture_size = 32'h333;
        wait_done(100, 0, lat);
        chk("sb_empty_5", 64'(sb.size()), 64'd0);
        @(posedge clock); #1;

        // Asynchronous reset while table beat 2 is stalled.
        tbl[0] = 16'h10; tbl[1] = 16'h20; tbl[2] = 16'h30; tbl[3] = 16'h40;
        push_seq(32'h99, 4, 2'd2);
        start_seq(32'h99, 16'd4, 2'd2);
        begin
            int k;
            k = 0;
            while (!(output_enable && slice_rd_addr == 3'd2) && k < 50) begin
                @(posedge clock); #1;
                k++;
            end
            chk("reach_tbl2", 64'(slice_rd_addr), 64'd2);
        end
        ready_mode = 2;
        ready = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_idle_outputs("midreset");
        sb.delete();
        @(negedge clock); #2;
        reset_n = 1'b1;
        ready_mode = 0;
        ready = 1'b1;
        @(posedge clock); #1;
        push_seq(32'h99, 4, 2'd2);
        start_seq(32'h99, 16'd4, 2'd2);
        wait_done(100, 0, lat);
        chk("lat_after_reset", 64'(lat + 1), 64'(12 + FL));
        chk("sb_empty_6", 64'(sb.size()), 64'd0);
        @(posedge clock); #1;
        check_idle_outputs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

endmodule
